// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates the instruction-fetch and data line ports onto a
// single physical-memory line interface. Partial-line data stores are turned
// into a read-modify-write pair of physical transactions.
// Optional feature: define MEM_ARB_LINE_BUFFER_EN to add a single-entry fetch
// line buffer that answers repeated fetches of the same line without pmem.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LINE_W = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  ifetch_read,
  input  logic [ADDR_W-1:0]     ifetch_address,
  output logic [LINE_W-1:0]     ifetch_rdata,
  output logic                  ifetch_resp,

  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_W-1:0]     mem_address,
  input  logic [LINE_W-1:0]     mem_wdata,
  input  logic [LINE_W/8-1:0]   mem_sel,
  output logic [LINE_W-1:0]     mem_rdata,
  output logic                  mem_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_W-1:0]     pmem_address,
  output logic [LINE_W-1:0]     pmem_wdata,
  input  logic [LINE_W-1:0]     pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int unsigned SEL_W = LINE_W / 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IF_RD    = 3'd1,
    D_RD     = 3'd2,
    D_RMW_RD = 3'd3,
    D_WR     = 3'd4,
    RESP     = 3'd5
  } state_t;

  typedef enum logic {
    GRANT_IF   = 1'b0,
    GRANT_DATA = 1'b1
  } grant_t;

  state_t             state_q, state_d;
  grant_t             grant_q, grant_d;
  grant_t             last_grant_q, last_grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [LINE_W-1:0]  merge_d;
  logic               data_req_c;
  logic               resp_if_c;
  logic               resp_data_c;

`ifdef MEM_ARB_LINE_BUFFER_EN
  logic               buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0]  buf_tag_q, buf_tag_d;
  logic [LINE_W-1:0]  buf_line_q, buf_line_d;
`endif

  // A data request is pending when either strobe is high; write dominates read
  assign data_req_c  = mem_read | mem_write;
  assign resp_if_c   = (state_d == RESP) && (grant_d == GRANT_IF);
  assign resp_data_c = (state_d == RESP) && (grant_d == GRANT_DATA);

  // Next-state, grant, address latch, line capture and byte merge
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    line_d       = line_q;
    addr_d       = pmem_address;
    merge_d      = pmem_wdata;
`ifdef MEM_ARB_LINE_BUFFER_EN
    buf_valid_d  = buf_valid_q;
    buf_tag_d    = buf_tag_q;
    buf_line_d   = buf_line_q;
`endif

    case (state_q)
      IDLE: begin
        // Data wins when it is alone or when fetch was granted last
        if (data_req_c && (!ifetch_read || (last_grant_q == GRANT_IF))) begin
          grant_d      = GRANT_DATA;
          last_grant_d = GRANT_DATA;
          addr_d       = mem_address;
          sel_d        = mem_sel;
          merge_d      = mem_wdata;
          if (mem_write) begin
`ifdef MEM_ARB_LINE_BUFFER_EN
            if (buf_valid_q && (buf_tag_q == mem_address)) begin
              buf_valid_d = 1'b0;
            end
`endif
            if (mem_sel == {SEL_W{1'b1}}) begin
              state_d = D_WR;
            end else if (mem_sel == {SEL_W{1'b0}}) begin
              // Nothing to write: acknowledge without touching pmem
              line_d  = '0;
              state_d = RESP;
            end else begin
              state_d = D_RMW_RD;
            end
          end else begin
            state_d = D_RD;
          end
        end else if (ifetch_read) begin
          grant_d      = GRANT_IF;
          last_grant_d = GRANT_IF;
          addr_d       = ifetch_address;
`ifdef MEM_ARB_LINE_BUFFER_EN
          if (buf_valid_q && (buf_tag_q == ifetch_address)) begin
            line_d  = buf_line_q;
            state_d = RESP;
          end else begin
            state_d = IF_RD;
          end
`else
          state_d = IF_RD;
`endif
        end
      end

      IF_RD: begin
        if (pmem_resp) begin
          line_d  = pmem_rdata;
          state_d = RESP;
`ifdef MEM_ARB_LINE_BUFFER_EN
          buf_valid_d = 1'b1;
          buf_tag_d   = pmem_address;
          buf_line_d  = pmem_rdata;
`endif
        end
      end

      D_RD: begin
        if (pmem_resp) begin
          line_d  = pmem_rdata;
          state_d = RESP;
        end
      end

      D_RMW_RD: begin
        // The merge register still holds the store data latched at grant
        if (pmem_resp) begin
          line_d = pmem_rdata;
          for (int unsigned i = 0; i < SEL_W; i++) begin
            merge_d[8*i +: 8] = sel_q[i] ? pmem_wdata[8*i +: 8] : pmem_rdata[8*i +: 8];
          end
          state_d = D_WR;
        end
      end

      D_WR: begin
        if (pmem_resp) begin
          line_d  = pmem_wdata;
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latches and registered strobes/responses decoded from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_IF;
      last_grant_q <= GRANT_IF;
      sel_q        <= '0;
      line_q       <= '0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      ifetch_resp  <= 1'b0;
      mem_resp     <= 1'b0;
      ifetch_rdata <= '0;
      mem_rdata    <= '0;
`ifdef MEM_ARB_LINE_BUFFER_EN
      buf_valid_q  <= 1'b0;
      buf_tag_q    <= '0;
      buf_line_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      line_q       <= line_d;
      pmem_address <= addr_d;
      pmem_wdata   <= merge_d;
      pmem_read    <= (state_d == IF_RD) || (state_d == D_RD) || (state_d == D_RMW_RD);
      pmem_write   <= (state_d == D_WR);
      ifetch_resp  <= resp_if_c;
      mem_resp     <= resp_data_c;
      if (resp_if_c) begin
        ifetch_rdata <= line_d;
      end
      if (resp_data_c) begin
        mem_rdata <= line_d;
      end
`ifdef MEM_ARB_LINE_BUFFER_EN
      buf_valid_q  <= buf_valid_d;
      buf_tag_q    <= buf_tag_d;
      buf_line_q   <= buf_line_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tests for mem_port_arbiter with a
// fixed-latency physical memory responder.
module tb_mem_port_arbiter;

  logic          clk;
  logic          reset_n;
  logic          ifetch_read;
  logic [11:0]   ifetch_address;
  logic [127:0]  ifetch_rdata;
  logic          ifetch_resp;
  logic          mem_read;
  logic          mem_write;
  logic [11:0]   mem_address;
  logic [127:0]  mem_wdata;
  logic [15:0]   mem_sel;
  logic [127:0]  mem_rdata;
  logic          mem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [11:0]   pmem_address;
  logic [127:0]  pmem_wdata;
  logic [127:0]  pmem_rdata;
  logic          pmem_resp;

  int            n_checks;
  int            n_pass;

  // Physical memory model controls
  int            lat;
  int            cnt;
  logic          inject;
  logic [127:0]  mem_line;

  // Per-transaction observations
  int            t_cyc;
  int            t_rd;
  int            t_wr;
  int            t_first_rd;
  logic          t_overlap;
  logic          t_if;
  logic          t_mem;
  logic [127:0]  t_data;
  logic [11:0]   t_addr;
  logic [127:0]  t_wdata;
  logic          bad;

  localparam logic [127:0] L1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] L2 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
  localparam logic [127:0] L3 = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;
  localparam logic [127:0] L4 = 128'h44444444_44444444_44444444_44444444;
  localparam logic [127:0] L5 = 128'h55555555_55555555_55555555_55555555;
  localparam logic [127:0] L6 = 128'h66666666_66666666_66666666_66666666;

  mem_port_arbiter #(.ADDR_W(12), .LINE_W(128)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ifetch_read    (ifetch_read),
    .ifetch_address (ifetch_address),
    .ifetch_rdata   (ifetch_rdata),
    .ifetch_resp    (ifetch_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_sel        (mem_sel),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: pulses pmem_resp in the lat-th cycle of a strobe
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    cnt        = 0;
    forever begin
      @(negedge clk);
      if (inject) begin
        pmem_resp = 1'b1;
      end else if (pmem_read || pmem_write) begin
        cnt = cnt + 1;
        if (cnt >= lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mem_line;
          cnt        = 0;
        end else begin
          pmem_resp = 1'b0;
        end
      end else begin
        pmem_resp = 1'b0;
        cnt       = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs cycles 1..maxc after the request cycle until a response pulse
  task automatic run(input int maxc);
    t_cyc = 0; t_rd = 0; t_wr = 0; t_first_rd = 0; t_overlap = 1'b0;
    t_if = 1'b0; t_mem = 1'b0; t_data = '0; t_addr = '0; t_wdata = '0;
    for (int c = 1; c <= maxc; c++) begin
      step();
      if (pmem_read) begin
        t_rd = t_rd + 1;
        t_addr = pmem_address;
        if (t_first_rd == 0) t_first_rd = c;
      end
      if (pmem_write) begin
        t_wr = t_wr + 1;
        t_addr = pmem_address;
        t_wdata = pmem_wdata;
      end
      if (pmem_read && pmem_write) t_overlap = 1'b1;
      if (ifetch_resp || mem_resp) begin
        t_cyc  = c;
        t_if   = ifetch_resp;
        t_mem  = mem_resp;
        t_data = ifetch_resp ? ifetch_rdata : mem_rdata;
        if (ifetch_resp) ifetch_read = 1'b0;
        if (mem_resp) begin
          mem_read  = 1'b0;
          mem_write = 1'b0;
        end
        break;
      end
    end
    check("resp_seen", 128'(t_cyc != 0), 128'(1));
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    reset_n = 1'b0; inject = 1'b0; lat = 2; mem_line = '0;
    ifetch_read = 1'b0; ifetch_address = '0;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0; mem_sel = '0;

    // Reset values
    #12;
    check("rst_pmem_read",  128'(pmem_read),    128'(0));
    check("rst_pmem_write", 128'(pmem_write),   128'(0));
    check("rst_if_resp",    128'(ifetch_resp),  128'(0));
    check("rst_mem_resp",   128'(mem_resp),     128'(0));
    check("rst_if_rdata",   ifetch_rdata,       128'(0));
    check("rst_mem_rdata",  mem_rdata,          128'(0));
    check("rst_pmem_addr",  128'(pmem_address), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Tie from reset: data first, then the fetch, then data again
    lat = 2; mem_line = L2;
    ifetch_read = 1'b1; ifetch_address = 12'h100;
    mem_read = 1'b1; mem_address = 12'h200;
    run(20);
    check("arb1_mem",  128'(t_mem),  128'(1));
    check("arb1_addr", 128'(t_addr), 128'(12'h200));
    check("arb1_cyc",  128'(t_cyc),  128'(3));
    check("arb1_data", t_data,       L2);
    mem_read = 1'b1; mem_address = 12'h201;
    step();
    run(20);
    check("arb2_if",   128'(t_if),   128'(1));
    check("arb2_addr", 128'(t_addr), 128'(12'h100));
    step();
    run(20);
    check("arb3_mem",  128'(t_mem),  128'(1));
    check("arb3_addr", 128'(t_addr), 128'(12'h201));
    step();

    // Fetch with 3-cycle pmem latency
    lat = 3; mem_line = L1;
    ifetch_read = 1'b1; ifetch_address = 12'h010;
    run(20);
    check("fetch_cyc",      128'(t_cyc),      128'(4));
    check("fetch_first_rd", 128'(t_first_rd), 128'(1));
    check("fetch_rd_cyc",   128'(t_rd),       128'(3));
    check("fetch_if",       128'(t_if),       128'(1));
    check("fetch_data",     t_data,           L1);
    check("fetch_addr",     128'(t_addr),     128'(12'h010));
    step();

    // Partial store: read-modify-write
    lat = 3; mem_line = {16{8'h11}};
    mem_write = 1'b1; mem_address = 12'h0A3; mem_sel = 16'h0003;
    mem_wdata = {{14{8'h77}}, 16'hBEEF};
    run(30);
    check("rmw_cyc",     128'(t_cyc),     128'(7));
    check("rmw_rd",      128'(t_rd),      128'(3));
    check("rmw_wr",      128'(t_wr),      128'(3));
    check("rmw_overlap", 128'(t_overlap), 128'(0));
    check("rmw_wdata",   t_wdata,         {{14{8'h11}}, 16'hBEEF});
    check("rmw_addr",    128'(t_addr),    128'(12'h0A3));
    check("rmw_rdata",   t_data,          {{14{8'h11}}, 16'hBEEF});
    step();
    check("rmw_one_pulse", 128'(mem_resp), 128'(0));

    // Full-line store with read and write both high
    lat = 2; mem_line = L1;
    mem_read = 1'b1; mem_write = 1'b1; mem_address = 12'h0B0; mem_sel = 16'hFFFF; mem_wdata = L3;
    run(20);
    check("full_cyc",   128'(t_cyc), 128'(3));
    check("full_rd",    128'(t_rd),  128'(0));
    check("full_wr",    128'(t_wr),  128'(2));
    check("full_wdata", t_wdata,     L3);
    check("full_rdata", t_data,      L3);
    step();

    // Empty byte select: immediate response, no pmem activity
    mem_write = 1'b1; mem_address = 12'h0C0; mem_sel = 16'h0000; mem_wdata = L2;
    run(10);
    check("sel0_cyc", 128'(t_cyc), 128'(1));
    check("sel0_mem", 128'(t_mem), 128'(1));
    check("sel0_rd",  128'(t_rd),  128'(0));
    check("sel0_wr",  128'(t_wr),  128'(0));
    step();

    // Repeated fetch of one line, then a store to it, then a fetch
    lat = 2; mem_line = L4;
    ifetch_read = 1'b1; ifetch_address = 12'h020;
    run(20);
    check("buf_fill_cyc", 128'(t_cyc), 128'(3));
    check("buf_fill_rd",  128'(t_rd),  128'(2));
    step();
    mem_line = L5;
    ifetch_read = 1'b1; ifetch_address = 12'h020;
    run(20);
`ifdef MEM_ARB_LINE_BUFFER_EN
    check("buf_hit_cyc",  128'(t_cyc), 128'(1));
    check("buf_hit_rd",   128'(t_rd),  128'(0));
    check("buf_hit_data", t_data,      L4);
`else
    check("nobuf_cyc",  128'(t_cyc), 128'(3));
    check("nobuf_rd",   128'(t_rd),  128'(2));
    check("nobuf_data", t_data,      L5);
`endif
    step();
    mem_write = 1'b1; mem_address = 12'h020; mem_sel = 16'hFFFF; mem_wdata = L6;
    run(20);
    check("inval_store_wr", 128'(t_wr), 128'(2));
    step();
    mem_line = L6;
    ifetch_read = 1'b1; ifetch_address = 12'h020;
    run(20);
    check("inval_fetch_rd",   128'(t_rd), 128'(2));
    check("inval_fetch_data", t_data,     L6);
    step();

    // Reset in the middle of a read-modify-write
    lat = 5; mem_line = {16{8'h22}};
    mem_write = 1'b1; mem_address = 12'h0D0; mem_sel = 16'h00F0; mem_wdata = L3;
    step();
    step();
    check("mid_rd_active", 128'(pmem_read), 128'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_rd", 128'(pmem_read),  128'(0));
    check("mid_rst_wr", 128'(pmem_write), 128'(0));
    mem_write = 1'b0; mem_sel = '0;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    inject  = 1'b1;
    @(negedge clk);
    #1;
    inject = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (pmem_read || pmem_write || ifetch_resp || mem_resp) bad = 1'b1;
    end
    check("late_resp_ignored", 128'(bad), 128'(0));

    // Normal service after the reset
    lat = 1; mem_line = L2;
    ifetch_read = 1'b1; ifetch_address = 12'h050;
    run(10);
    check("post_rst_cyc",  128'(t_cyc), 128'(2));
    check("post_rst_data", t_data,      L2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Memory-side responder for the pipelined LC-3b datapath's two line-granular ports: instruction fetch (read-only) and data (read/write with byte select). It arbitrates both onto a single physical-memory line interface and performs read-modify-write for partial-line data stores. It returns one-cycle response pulses with the requested line.

## Interface
Parameters:
- ADDR_W, 12, line address width (lc3b_wb_adr)
- LINE_W, 128, line width in bits (lc3b_line / lc3b_c_line)

Ports:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ifetch_read  in  1  fetch request, level, held until ifetch_resp
- ifetch_address  in  12  fetch line address
- ifetch_rdata  out  128  fetch line, valid while ifetch_resp=1
- ifetch_resp  out  1  one-cycle completion pulse
- mem_read  in  1  data read request, level, held until mem_resp
- mem_write  in  1  data write request, level, held until mem_resp
- mem_address  in  12  data line address
- mem_wdata  in  128  store line data
- mem_sel  in  16  byte enables; bit i selects mem_wdata[8i+7:8i]
- mem_rdata  out  128  data line, valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  physical read strobe, held until pmem_resp
- pmem_write  out  1  physical write strobe, held until pmem_resp
- pmem_address  out  12  physical line address
- pmem_wdata  out  128  physical write line
- pmem_rdata  in  128  physical read line, valid with pmem_resp
- pmem_resp  in  1  physical completion pulse

## Operation
- States: IDLE, IF_RD, D_RD, D_RMW_RD, D_WR, RESP.
- IDLE: no pending request → stay. One port pending → grant it. Both pending → grant port not granted last (last_grant register, reset = ifetch, so data wins first tie).
- Grant ifetch → IF_RD. Grant data read → D_RD. Data write: mem_sel=16'hFFFF → D_WR with pmem_wdata=mem_wdata; mem_sel=0 → RESP directly, no pmem access; otherwise → D_RMW_RD.
- mem_read and mem_write both high: treated as write.
- IF_RD / D_RD / D_RMW_RD: pmem_read=1, pmem_address = granted address latched at grant. On pmem_resp capture pmem_rdata into line register; IF_RD/D_RD → RESP; D_RMW_RD → D_WR with merged line: byte i = mem_sel[i] ? mem_wdata byte i : pmem_rdata byte i.
- D_WR: pmem_write=1, pmem_wdata = merge register; on pmem_resp → RESP.
- RESP: pulse resp of granted port for exactly one cycle; rdata output = line register (write responses drive the merged/written line); → IDLE.
- pmem_read and pmem_write never high together; strobes are pure state decodes.
- Request inputs are sampled only in IDLE; changes during service are ignored (requester must hold them).

## Timing
- Reset (async assert, sync release): state IDLE, all strobes/resp 0, rdata outputs 0, line/merge registers 0, last_grant=ifetch, line buffer invalid.
- Read latency: request seen in IDLE cycle 0, pmem strobe cycles 1..k (pmem_resp in cycle k), resp in cycle k+1.
- Partial write: two pmem transactions back to back, no idle cycle between; resp one cycle after second pmem_resp.
- mem_sel=0 write: resp in cycle 1.
- Earliest re-grant: cycle after RESP; no back-to-back resp on the same port.
- Reset mid-transaction: strobes drop immediately; in-flight pmem_resp after reset is ignored.

## Configuration
- MEM_ARB_LINE_BUFFER_EN defined: single-entry fetch line buffer (valid, tag, 128-bit line). Filled at every IF_RD completion. Ifetch grant with valid && tag match → RESP directly (resp in cycle 1, no pmem access). Any data write whose address matches tag clears valid at grant time.
- Not defined: no buffer; every fetch goes to pmem.

## Test plan
- Fetch addr 12'h010, pmem returns 128'h0123…CDEF after 3 cycles → pmem_read cycles 1–3, ifetch_resp cycle 4 with that line, pmem_address=12'h010.
- Partial store addr 12'h0A3, mem_sel=16'h0003, wdata[15:0]=16'hBEEF, pmem line all 8'h11 → read then write; pmem_wdata bytes0–1 = EF,BE, bytes2–15 = 11; one mem_resp.
- ifetch_read and mem_read asserted together from reset → data served first, then ifetch; then both again → ifetch first (alternation).
- Full-line store mem_sel=16'hFFFF → single pmem_write, no pmem_read; mem_sel=0 store → mem_resp cycle 1, no pmem strobes.
- reset_n pulsed low while in D_RMW_RD → strobes 0 same cycle, state IDLE, late pmem_resp produces no resp.
- With MEM_ARB_LINE_BUFFER_EN: fetch 12'h020 twice → second resp in cycle 1 without pmem_read; store to 12'h020 then fetch → pmem_read issued.
